// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO in front of the UART transmitter: buffers CPU writes and
// feeds them one at a time through the tx_begin/tx_busy handshake.
module uart_tx_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          all_sent,
  output logic [7:0]    tx_data,
  output logic          tx_begin,
  input  logic          tx_busy,
  output logic [1:0]    state_dbg
);

  // Handshake: a byte is offered while tx_begin=1 (state REQ, tx_data held);
  // the transmitter accepts by raising tx_busy, which drops tx_begin on the
  // same edge; the byte is finished once tx_busy returns low.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam int DEPTH_I = 1 << AW;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [7:0]    mem [DEPTH_I];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic          overflow_q;
  logic [7:0]    tx_data_q;
  logic          tx_begin_q;
  state_t        state;
  state_t        state_next;
  logic          wr_ok;
  logic          pop;

  assign full      = (level_q == DEPTH);
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign tx_data   = tx_data_q;
  assign tx_begin  = tx_begin_q;
  assign state_dbg = state;
  assign all_sent  = empty && (state == S_IDLE) && !tx_busy;

  // full is taken before any same-cycle pop, so a write into a full FIFO drops.
  assign wr_ok = wr_en && !full && !flush;
  assign pop   = (state == S_IDLE) && !empty && !tx_busy && !flush;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (pop) state_next = S_REQ;
      S_REQ:  if (tx_busy) state_next = S_WAIT;
      S_WAIT: if (!tx_busy) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tx_begin_q <= 1'b0;
    end else begin
      state      <= state_next;
      tx_begin_q <= (state_next == S_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (wr_en && full) overflow_q <= 1'b1;
      if (pop) begin
        tx_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      level_q <= level_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a transmitter model answers tx_begin, a monitor
// compares every offered byte against the expected queue.
module tb_uart_tx_fifo;

  localparam int AW = 4;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        flush;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        overflow;
  logic        all_sent;
  logic [7:0]  tx_data;
  logic        tx_begin;
  logic        tx_busy;
  logic [1:0]  state_dbg;

  logic        force_busy;
  logic        model_busy;
  logic        auto_en;
  int          busy_len;
  int          busy_cnt;

  logic [7:0]  exp_q[$];
  int          checks;
  int          errors;
  int          tx_count;
  logic        prev_begin;
  logic [7:0]  cur_byte;

  assign tx_busy = force_busy | model_busy;

  uart_tx_fifo #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .all_sent(all_sent), .tx_data(tx_data), .tx_begin(tx_begin),
    .tx_busy(tx_busy), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: accept a request after seeing tx_begin, stay busy busy_len cycles.
  always @(negedge clk) begin
    if (busy_cnt != 0) busy_cnt--;
    else if (tx_begin && auto_en) busy_cnt = busy_len;
    model_busy = (busy_cnt != 0);
  end

  // Monitor: each new request must carry the next expected byte, held stable.
  always @(negedge clk) begin
    if (tx_begin && !prev_begin) begin
      tx_count++;
      cur_byte = tx_data;
      if (exp_q.size() == 0) check("unexpected_tx_begin", 32'(tx_data), 32'hFFFF_FFFF);
      else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end else if (tx_begin && prev_begin) begin
      check("tx_data_stable", 32'(tx_data), 32'(cur_byte));
    end
    prev_begin = tx_begin;
  end

  // Driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic expect_out);
    wr_en = 1'b1;
    wr_data = b;
    if (expect_out) exp_q.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(all_sent && exp_q.size() == 0) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n;
    int cnt0;
    checks = 0; errors = 0; tx_count = 0;
    prev_begin = 1'b0; cur_byte = 8'h00;
    busy_cnt = 0; model_busy = 1'b0; busy_len = 3; auto_en = 1'b1;
    force_busy = 1'b0;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_begin", 32'(tx_begin), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_all_sent", 32'(all_sent), 32'd1);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Single byte latency
    write_byte(8'hA5, 1'b1);
    check("t1_level_after_write", 32'(level), 32'd1);
    check("t1_begin_low_at_write", 32'(tx_begin), 32'd0);
    step();
    check("t1_level_after_pop", 32'(level), 32'd0);
    check("t1_begin_high", 32'(tx_begin), 32'd1);
    check("t1_tx_data", 32'(tx_data), 32'hA5);
    step();
    check("t1_busy_seen", 32'(tx_busy), 32'd1);
    check("t1_begin_dropped", 32'(tx_begin), 32'd0);
    wait_idle("t1_done", 50);

    // Fill to full with transmitter stalled, then overflow
    force_busy = 1'b1;
    busy_len = 2;
    step();
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      exp_q.push_back(8'(i));
      step();
    end
    write_byte(8'h11, 1'b0);
    check("t2_full", 32'(full), 32'd1);
    check("t2_level", 32'(level), 32'd16);
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_no_tx", 32'(tx_begin), 32'd0);
    force_busy = 1'b0;
    wait_idle("t2_drain", 200);
    check("t2_all_sent", 32'(all_sent), 32'd1);
    check("t2_overflow_sticky", 32'(overflow), 32'd1);

    // Flush while idle clears overflow
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle_overflow", 32'(overflow), 32'd0);

    // Sustained traffic through pointer wrap
    busy_len = 1;
    for (int i = 0; i < 48; i++) begin
      write_byte(8'(8'h40 + i), 1'b1);
      step();
      step();
    end
    wait_idle("t3_drain", 300);
    check("t3_overflow", 32'(overflow), 32'd0);
    check("t3_level", 32'(level), 32'd0);

    // Write coinciding with a pop at level 3
    busy_len = 3;
    force_busy = 1'b1;
    step();
    write_byte(8'hC1, 1'b1);
    write_byte(8'hC2, 1'b1);
    write_byte(8'hC3, 1'b1);
    check("t4_level_before", 32'(level), 32'd3);
    force_busy = 1'b0;
    write_byte(8'hC4, 1'b1);
    check("t4_level_same", 32'(level), 32'd3);
    check("t4_popped", 32'(tx_begin), 32'd1);
    wait_idle("t4_drain", 200);

    // Flush in WAIT with 5 bytes still queued
    busy_len = 4;
    force_busy = 1'b1;
    step();
    for (int i = 0; i < 16; i++) write_byte(8'(8'h80 + i), 1'b1);
    write_byte(8'hEE, 1'b0);
    check("t5_overflow_set", 32'(overflow), 32'd1);
    force_busy = 1'b0;
    n = 0;
    while (!(state_dbg == 2'd2 && level == 5) && n < 300) begin
      step();
      n++;
    end
    check("t5_reach_wait5", 32'(n < 300), 32'd1);
    check("t5_queued_model", 32'(exp_q.size()), 32'd5);
    exp_q.delete();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_level", 32'(level), 32'd0);
    check("t5_overflow_cleared", 32'(overflow), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    cnt0 = tx_count;
    wait_idle("t5_inflight_done", 50);
    repeat (20) step();
    check("t5_no_more_tx", 32'(tx_count), 32'(cnt0));
    check("t5_all_sent", 32'(all_sent), 32'd1);

    // Reset during REQ with transmitter held busy
    auto_en = 1'b0;
    write_byte(8'hB0, 1'b1);
    n = 0;
    while (!tx_begin && n < 20) begin
      step();
      n++;
    end
    check("t6_reach_req", 32'(tx_begin), 32'd1);
    force_busy = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6_begin_low", 32'(tx_begin), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_state", 32'(state_dbg), 32'd0);
    check("t6_all_sent_busy", 32'(all_sent), 32'd0);
    cnt0 = tx_count;
    write_byte(8'hB1, 1'b1);
    repeat (5) step();
    check("t6_held_level", 32'(level), 32'd1);
    check("t6_no_tx_while_busy", 32'(tx_count), 32'(cnt0));
    auto_en = 1'b1;
    force_busy = 1'b0;
    wait_idle("t6_drain", 50);
    check("t6_one_tx", 32'(tx_count), 32'(cnt0 + 1));

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer that sits directly upstream of the UART transmitter. The CPU register logic writes bytes at bus speed.
- The block stores those bytes in a synchronous FIFO, then presents them one at a time to the transmitter using its txbegin/txbusy handshake.
- Removes the one-byte-at-a-time polling limit on the UART data register.
- Reports fill level, full/empty, overflow and all-sent status for the UART status register.

Parameters:
- AW, 4, FIFO address width; depth = 2^AW entries (default 16).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- wr_en  in  1  single-cycle write strobe from register decode
- wr_data  in  8  byte to enqueue
- flush  in  1  synchronous FIFO clear, one-cycle pulse
- full  out  1  FIFO holds 2^AW entries
- empty  out  1  FIFO holds 0 entries
- level  out  AW+1  current entry count, 0..2^AW
- overflow  out  1  sticky; set when a write is dropped
- all_sent  out  1  FIFO empty AND FSM in IDLE AND tx_busy==0
- tx_data  out  8  byte to transmitter, stable throughout REQ
- tx_begin  out  1  start request to transmitter
- tx_busy  in  1  transmitter busy flag

Behaviour:
- Reset (rst_n==0 at a clk edge):
  - Pointers and level are zeroed; empty=1, full=0.
  - overflow=0, tx_begin=0, tx_data=8'h00, FSM goes to IDLE.
  - Any entry that was mid-handshake is discarded.
  - all_sent follows its definition and can be 0 right after reset while the transmitter is still busy.
- Storage: a 2^AW x 8 array with wr_ptr/rd_ptr of AW bits that wrap modulo 2^AW. level is a separate AW+1-bit counter.
  - full = (level == 2^AW); empty = (level == 0).
- Write: when wr_en=1 and full=0, data is stored at wr_ptr, wr_ptr increments and level increments.
  - When wr_en=1 and full=1, the write is dropped, overflow is set to 1, and pointers and level are unchanged.
- Pop: happens only on the FSM transition IDLE->REQ. It loads tx_data from mem[rd_ptr], increments rd_ptr and decrements level.
- Write and pop in the same cycle: both happen and level is unchanged.
  - If full is 1 that cycle, the write is still dropped, because full is evaluated before the pop.
- flush=1: wr_ptr, rd_ptr and level are cleared and overflow is cleared.
  - A concurrent wr_en is ignored.
  - The FSM is not affected: a byte already popped into REQ/WAIT completes normally.
  - A pop in the same cycle as flush is suppressed, so the FSM stays in IDLE.
- Handshake FSM, three states:
  - IDLE: tx_begin=0. If empty=0 and tx_busy=0, pop into tx_data and go to REQ.
  - REQ: tx_begin=1 and tx_data is held. When tx_busy=1, drop tx_begin to 0 in the same transition and go to WAIT. The transmitter only shifts when its txbegin is 0, so tx_begin must be low from the first WAIT cycle.
  - WAIT: tx_begin=0. When tx_busy=0, go to IDLE.
- Latency, empty FIFO and idle transmitter:
  - wr_en at edge N stores the byte.
  - Edge N+1 pops it; tx_begin=1 is visible after N+1.
  - The next queued byte reaches REQ at the earliest 2 cycles after tx_busy falls (WAIT->IDLE, then IDLE->REQ).
- tx_busy stuck at 1 after reset: the FSM stays in IDLE with no pop until tx_busy falls.
- tx_begin is a registered output with no combinational path from any input.
- Bytes leave in strict FIFO order; the AW-bit pointer wrap is invisible to the output order.

Test Plan:
- Reset with tx_busy=0, write 8'hA5 once → all four hold:
  - level goes 0→1 then back to 0.
  - tx_begin rises one cycle after the write.
  - tx_data=8'hA5 while tx_begin is high.
  - tx_begin falls on the first cycle tx_busy=1.
- Write 8'h01..8'h10 back-to-back (AW=4), then 8'h11 with the transmitter model stalled → all hold:
  - full=1 and level=16.
  - 8'h11 is dropped and overflow=1.
  - Releasing the transmitter yields 8'h01..8'h10 in order.
  - all_sent=1 at the end.
- Sustained writes interleaved with pops, pushing more than 40 bytes through a 16-entry FIFO → wrap-around works and the output sequence equals the input sequence exactly.
- Write on the same edge as an IDLE->REQ pop with level=3 → level stays 3 and the write is stored.
- flush while in WAIT with 5 bytes queued → all hold:
  - level=0 and overflow is cleared.
  - The byte in flight completes.
  - No further tx_begin pulses occur.
- Assert rst_n=0 during REQ while tx_busy is held at 1 → all hold:
  - tx_begin goes low.
  - level=0.
  - No pop occurs until tx_busy falls.
  - A new write is transmitted only after that.
